// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states,
// instruction classes, datapath select codes and the per-state strobe table.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_REL  = 2'b01;
    localparam logic [1:0] PC_SRC_JALR = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [1:0] ALU_OP_R      = 2'b00;
    localparam logic [1:0] ALU_OP_ADDR   = 2'b01;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b10;
    localparam logic [1:0] ALU_OP_LUI    = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_R      = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_OPIMM  = 4'd5,
        CLS_LUI    = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } iclass_t;

    // branch_exec / store_mem mark states whose final strobes also need a live input
    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       dmem_req;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       instr_retired;
        logic       fault;
        logic       branch_exec;
        logic       store_mem;
    } ctrl_t;

    function automatic iclass_t decode_class(input logic [6:0] op);
        iclass_t cls;
        case (op)
            OP_R:      cls = CLS_R;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_OPIMM:  cls = CLS_OPIMM;
            OP_LUI:    cls = CLS_LUI;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            default:   cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    function automatic ctrl_t moore_ctrl(input state_t st, input iclass_t cls);
        ctrl_t c;
        c = '0;
        case (st)
            ST_EXEC: begin
                case (cls)
                    CLS_R: begin
                        c.alu_src = 1'b0;
                        c.alu_op  = ALU_OP_R;
                    end
                    CLS_LOAD, CLS_STORE, CLS_OPIMM: begin
                        c.alu_src = 1'b1;
                        c.alu_op  = ALU_OP_ADDR;
                    end
                    CLS_BRANCH: begin
                        c.alu_src       = 1'b0;
                        c.alu_op        = ALU_OP_BRANCH;
                        c.pc_write      = 1'b1;
                        c.instr_retired = 1'b1;
                        c.branch_exec   = 1'b1;
                    end
                    CLS_LUI: begin
                        c.alu_src = 1'b1;
                        c.alu_op  = ALU_OP_LUI;
                    end
                    CLS_JAL, CLS_JALR: begin
                        c.alu_src = 1'b1;
                        c.alu_op  = ALU_OP_R;
                    end
                    default: c.alu_op = ALU_OP_R;
                endcase
            end
            ST_MEM: begin
                c.dmem_req  = 1'b1;
                c.mem_read  = (cls == CLS_LOAD);
                c.mem_write = (cls == CLS_STORE);
                c.store_mem = (cls == CLS_STORE);
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_OP_ADDR;
            end
            ST_WB: begin
                c.reg_write     = 1'b1;
                c.pc_write      = 1'b1;
                c.instr_retired = 1'b1;
                if (cls == CLS_LOAD) begin
                    c.wb_sel = WB_SEL_MEM;
                end else if (cls == CLS_JAL || cls == CLS_JALR) begin
                    c.wb_sel = WB_SEL_PC4;
                end else begin
                    c.wb_sel = WB_SEL_ALU;
                end
                if (cls == CLS_JAL) begin
                    c.pc_src = PC_SRC_REL;
                end else if (cls == CLS_JALR) begin
                    c.pc_src = PC_SRC_JALR;
                end else begin
                    c.pc_src = PC_SRC_SEQ;
                end
            end
            ST_FAULT: c.fault = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Wait-cycle counter shared by the instruction-fetch and data-memory waits;
// limit_hit flags the last permitted cycle. LIMIT of 0 never hits.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic limit_hit
);

    localparam int unsigned    CW    = (LIMIT > 32'd1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0]  LIM_V = (LIMIT > 32'd0) ? CW'(LIMIT - 32'd1) : '0;

    logic [CW-1:0] count_r;

    assign limit_hit = (LIMIT != 32'd0) && (count_r == LIM_V);

    // Counts stalled request cycles; restarts whenever a new wait begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (count_en && !limit_hit) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Define MULTICYCLE_PERF_EN to add the cycle_count / instret_count counters.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        alu_zero,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        instr_retired,
    output logic        fault,
    output logic [2:0]  state_dbg
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    state_t  state_r;
    state_t  state_next_s;
    iclass_t cls_r;
    iclass_t cls_next_s;
    iclass_t dec_cls_s;
    ctrl_t   ctrl_r;
    logic    fetch_act_s;
    logic    limit_hit_s;
    logic    timer_clr_s;
    logic    timer_en_s;

    // rst_n qualifies the fetch request so it drops the moment reset asserts
    assign fetch_act_s = rst_n && (state_r == ST_FETCH) && run;

    // Next-state and class-latch decisions
    always_comb begin
        state_next_s = state_r;
        cls_next_s   = cls_r;
        dec_cls_s    = decode_class(opcode);
        case (state_r)
            ST_FETCH: begin
                if (run && imem_ready) begin
                    state_next_s = ST_DECODE;
                end else if (run && limit_hit_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                cls_next_s = dec_cls_s;
                if (dec_cls_s == CLS_NONE) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_r)
                    CLS_BRANCH:          state_next_s = ST_FETCH;
                    CLS_LOAD, CLS_STORE: state_next_s = ST_MEM;
                    default:             state_next_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_next_s = (cls_r == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (limit_hit_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB:    state_next_s = ST_FETCH;
            ST_FAULT: state_next_s = ST_FAULT;
            default:  state_next_s = ST_FAULT;
        endcase
    end

    // Timer restarts on any state change or while fetch is parked with run low
    always_comb begin
        timer_clr_s = (state_next_s != state_r) || ((state_r == ST_FETCH) && !run);
        timer_en_s  = (fetch_act_s && !imem_ready) || ((state_r == ST_MEM) && !dmem_ready);
    end

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clr_s),
        .count_en  (timer_en_s),
        .limit_hit (limit_hit_s)
    );

    // State, latched class and the state-derived strobes, registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            cls_r   <= CLS_NONE;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_next_s;
            cls_r   <= cls_next_s;
            ctrl_r  <= moore_ctrl(state_next_s, cls_next_s);
        end
    end

    // Merge registered strobes with the handshake and zero-flag terms
    always_comb begin
        imem_req      = fetch_act_s;
        ir_write      = fetch_act_s && imem_ready;
        dmem_req      = ctrl_r.dmem_req;
        mem_read      = ctrl_r.mem_read;
        mem_write     = ctrl_r.mem_write;
        reg_write     = ctrl_r.reg_write;
        wb_sel        = ctrl_r.wb_sel;
        alu_src       = ctrl_r.alu_src;
        alu_op        = ctrl_r.alu_op;
        fault         = ctrl_r.fault;
        state_dbg     = state_r;
        pc_write      = ctrl_r.pc_write || (ctrl_r.store_mem && dmem_ready);
        instr_retired = ctrl_r.instr_retired || (ctrl_r.store_mem && dmem_ready);
        if (ctrl_r.branch_exec) begin
            pc_src = alu_zero ? PC_SRC_REL : PC_SRC_SEQ;
        end else begin
            pc_src = ctrl_r.pc_src;
        end
    end

`ifdef MULTICYCLE_PERF_EN
    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count   <= 32'd0;
            instret_count <= 32'd0;
        end else begin
            if (state_r != ST_FAULT) begin
                cycle_count <= cycle_count + 32'd1;
            end else begin
                cycle_count <= cycle_count;
            end
            if (instr_retired) begin
                instret_count <= instret_count + 32'd1;
            end else begin
                instret_count <= instret_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a responder issues random instructions and memory delays,
// a monitor checks each retirement against a per-instruction reference model.
module tb_multicycle_controller;

    localparam int N_INSTR = 60;

    logic        clk = 1'b0;
    logic        rst_n, run, alu_zero, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic        imem_req, dmem_req, ir_write, pc_write, alu_src, mem_read, mem_write;
    logic        reg_write, instr_retired, fault;
    logic [1:0]  pc_src, alu_op, wb_sel;
    logic [2:0]  state_dbg;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_count, instret_count;
`endif

    int   total = 0;
    int   bad = 0;
    int   retired = 0;
    logic resp_en = 1'b0;
    logic mon_en = 1'b0;

    typedef struct {
        int         cycles;
        logic [1:0] pc_src;
        int         rw;
        logic [1:0] wb_sel;
        int         dm;
        int         mr;
        int         mw;
        logic [2:0] alu;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk (clk), .rst_n (rst_n), .run (run), .opcode (opcode), .alu_zero (alu_zero),
        .imem_req (imem_req), .imem_ready (imem_ready), .dmem_req (dmem_req),
        .dmem_ready (dmem_ready), .ir_write (ir_write), .pc_write (pc_write),
        .pc_src (pc_src), .alu_src (alu_src), .alu_op (alu_op), .mem_read (mem_read),
        .mem_write (mem_write), .reg_write (reg_write), .wb_sel (wb_sel),
        .instr_retired (instr_retired), .fault (fault), .state_dbg (state_dbg)
`ifdef MULTICYCLE_PERF_EN
        , .cycle_count (cycle_count), .instret_count (instret_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] op_of(input int k);
        case (k)
            0: return 7'b0110011;
            1: return 7'b0000011;
            2: return 7'b0100011;
            3: return 7'b1100011;
            4: return 7'b0010011;
            5: return 7'b0110111;
            6: return 7'b1101111;
            default: return 7'b1100111;
        endcase
    endfunction

    // Class k: 0 R,1 LOAD,2 STORE,3 BRANCH,4 OPIMM,5 LUI,6 JAL,7 JALR; alu = {alu_src, alu_op} in EXEC
    function automatic exp_t model(input int k, input int fd, input int md, input logic z);
        exp_t e;
        e.cycles = fd + 4; e.pc_src = 2'b00; e.rw = 1; e.wb_sel = 2'b00;
        e.dm = 0; e.mr = 0; e.mw = 0; e.alu = 3'b101;
        case (k)
            0: e.alu = 3'b000;
            1: begin e.cycles = fd + md + 5; e.wb_sel = 2'b01; e.dm = md + 1; e.mr = md + 1; end
            2: begin e.cycles = fd + md + 4; e.rw = 0; e.dm = md + 1; e.mw = md + 1; end
            3: begin e.cycles = fd + 3; e.rw = 0; e.pc_src = {1'b0, z}; e.alu = 3'b010; end
            5: e.alu = 3'b111;
            6: begin e.pc_src = 2'b01; e.wb_sel = 2'b10; e.alu = 3'b100; end
            7: begin e.pc_src = 2'b10; e.wb_sel = 2'b10; e.alu = 3'b100; end
            default: e.alu = 3'b101;
        endcase
        return e;
    endfunction

    // Responder: starts instructions, plays both memories with chosen delays
    initial begin
        int k, fd, md, icnt, mcnt, issued;
        logic z, in_fetch;
        fd = 0; md = 0; icnt = 0; mcnt = 0; issued = 0; in_fetch = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (state_dbg == 3'd0 && !in_fetch) begin
                    if (issued < N_INSTR) begin
                        case (issued)
                            0: begin k = 0; fd = 0; md = 0; z = 1'b0; end
                            1: begin k = 1; fd = 0; md = 3; z = 1'b0; end
                            2: begin k = 3; fd = 0; md = 0; z = 1'b1; end
                            3: begin k = 3; fd = 0; md = 0; z = 1'b0; end
                            4: begin k = 7; fd = 0; md = 0; z = 1'b0; end
                            5: begin k = 2; fd = 3; md = 3; z = 1'b1; end
                            default: begin
                                k = $urandom_range(7); fd = $urandom_range(3);
                                md = $urandom_range(3); z = 1'($urandom_range(1));
                            end
                        endcase
                        opcode = op_of(k); alu_zero = z; run = 1'b1;
                        exp_q.push_back(model(k, fd, md, z));
                        issued++; in_fetch = 1'b1; icnt = 0; mcnt = 0;
                    end else begin
                        run = 1'b0;
                    end
                end
                if (in_fetch) begin
                    imem_ready = (icnt == fd); icnt++;
                    if (imem_ready) in_fetch = 1'b0;
                end else begin
                    imem_ready = 1'b0;
                end
                if (dmem_req) begin
                    dmem_ready = (mcnt == md); mcnt++;
                end else begin
                    dmem_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: tallies strobes per instruction and scores them at retirement
    initial begin
        int cyc, irw, pcw, rw, dm, mr, mw;
        logic busy;
        logic [1:0] wbs;
        logic [2:0] alu;
        exp_t e;
        busy = 1'b0; cyc = 0; irw = 0; pcw = 0; rw = 0; dm = 0; mr = 0; mw = 0;
        wbs = 2'b00; alu = 3'b000;
        forever begin
            @(negedge clk); #2;
            if (!mon_en) begin
                busy = 1'b0;
            end else begin
                if (!busy && imem_req) begin
                    busy = 1'b1; cyc = 0; irw = 0; pcw = 0; rw = 0; dm = 0; mr = 0; mw = 0;
                    wbs = 2'b11; alu = 3'b011;
                end
                if (busy) begin
                    cyc++;
                    if (ir_write) irw++;
                    if (pc_write) pcw++;
                    if (reg_write) begin rw++; wbs = wb_sel; end
                    if (dmem_req) dm++;
                    if (mem_read) mr++;
                    if (mem_write) mw++;
                    if (state_dbg == 3'd2) alu = {alu_src, alu_op};
                    if (fault) begin
                        check("run_fault", fault, 1'b0);
                        busy = 1'b0;
                    end else if (instr_retired) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL sb_underflow: retirement with no expected entry");
                        end else begin
                            e = exp_q.pop_front();
                            check("cycles", cyc, e.cycles);
                            check("pc_src", pc_src, e.pc_src);
                            check("pc_write_n", pcw, 1);
                            check("ir_write_n", irw, 1);
                            check("reg_write_n", rw, e.rw);
                            if (e.rw != 0) check("wb_sel", wbs, e.wb_sel);
                            check("dmem_req_n", dm, e.dm);
                            check("mem_read_n", mr, e.mr);
                            check("mem_write_n", mw, e.mw);
                            check("alu_cfg", alu, e.alu);
                        end
                        retired++;
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk); #3;
        rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk); #3;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, bad_pc;
        rst_n = 1'b0; run = 1'b1; opcode = 7'd0; alu_zero = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_state", state_dbg, 3'd0);
        check("rst_strobes", {ir_write, pc_write, reg_write, dmem_req, instr_retired, fault}, 6'd0);
`ifdef MULTICYCLE_PERF_EN
        check("rst_perf", cycle_count | instret_count, 32'd0);
`endif
        #1; rst_n = 1'b1; run = 1'b0;
        // run low: ready must be ignored
        repeat (3) begin
            @(negedge clk); #2;
            check("idle_req", {imem_req, ir_write}, 2'b00);
            check("idle_state", state_dbg, 3'd0);
        end
        #1; imem_ready = 1'b0; mon_en = 1'b1; resp_en = 1'b1;
        for (int c = 0; c < 3000 && retired < N_INSTR; c++) @(negedge clk);
        check("retired", retired, N_INSTR);
        #3; resp_en = 1'b0; mon_en = 1'b0;
        check("sb_empty", exp_q.size(), 0);

        // Fetch timeout: four unanswered requests, then sticky fault
        reset_dut();
        @(negedge clk);
        run = 1'b1; nreq = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (fault) break;
            if (imem_req) nreq++;
            @(negedge clk);
        end
        check("timeout_reqs", nreq, 4);
        check("timeout_fault", fault, 1'b1);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #2;
            check("fault_sticky", {fault, state_dbg}, {1'b1, 3'd5});
            check("fault_quiet", {imem_req, ir_write, dmem_req, pc_write, reg_write,
                                  instr_retired, mem_read, mem_write}, 8'd0);
        end

        // Illegal opcode faults in DECODE without retiring
        reset_dut();
        @(negedge clk);
        opcode = 7'b1111111; run = 1'b1; imem_ready = 1'b1; bad_pc = 0;
        #2; check("ill_ir_write", ir_write, 1'b1);
        @(negedge clk); imem_ready = 1'b0;
        #2; check("ill_decode", state_dbg, 3'd1);
        if (pc_write || instr_retired) bad_pc++;
        @(negedge clk); #2;
        check("ill_fault", {fault, state_dbg}, {1'b1, 3'd5});
        if (pc_write || instr_retired) bad_pc++;
        check("ill_no_retire", bad_pc, 0);

        // Reset in the middle of a store's MEM wait
        reset_dut();
        @(negedge clk);
        opcode = 7'b0100011; run = 1'b1; imem_ready = 1'b1;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #2;
        check("sw_mem_write", {dmem_req, mem_write, state_dbg}, {1'b1, 1'b1, 3'd3});
        #1; rst_n = 1'b0;
        #1;
        check("rst_mid_mem", {dmem_req, mem_write, imem_req}, 3'b000);
        check("rst_mid_state", state_dbg, 3'd0);
`ifdef MULTICYCLE_PERF_EN
        check("rst_mid_perf", cycle_count | instret_count, 32'd0);
`endif
        @(negedge clk); #3; rst_n = 1'b1;
        @(negedge clk); #2;
        check("release_fetch", {imem_req, state_dbg}, {1'b1, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV32I datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Generates per-cycle datapath strobes: ALU config, memory requests, register write, PC update.
- Handshakes with instruction and data memories (req/ready).
- Sits between the IR/opcode decode and the shared ALU, memories and register file.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory req may wait for ready before entering FAULT; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- run  in  1  enables fetch; low holds in FETCH with no request
- opcode  in  7  instr[6:0] from IR, sampled in DECODE only
- alu_zero  in  1  ALU zero flag, used in EXEC for branches
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid
- dmem_req  out  1  data memory request
- dmem_ready  in  1  data access complete
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- pc_src  out  2  00 pc+4, 01 pc+imm, 10 rs1+imm (jalr)
- alu_src  out  1  0 rs2, 1 immediate
- alu_op  out  2  00 R, 01 I/addr, 10 branch-sub, 11 lui
- mem_read  out  1  load strobe
- mem_write  out  1  store strobe
- reg_write  out  1  register file write
- wb_sel  out  2  00 ALU, 01 memory, 10 pc+4
- instr_retired  out  1  one-cycle pulse per completed instruction
- fault  out  1  sticky error flag
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, rst_n=0):
  - State = FETCH.
  - Every output = 0; the timer and latched instruction class are cleared.
  - Strobes drop immediately on reset, including mid-operation.
- Outputs are Moore from state, the latched class and the ready/zero inputs. No output depends on opcode after DECODE.
- FETCH (0):
  - imem_req = run.
  - On imem_ready: ir_write pulses one cycle, then go to DECODE.
  - Ignore imem_ready when run=0.
- DECODE (1):
  - Exactly one cycle. Latch class from opcode: R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, OPIMM 0010011, LUI 0110111, JAL 1101111, JALR 1100111.
  - Any other opcode: go to FAULT. Otherwise go to EXEC.
- EXEC (2):
  - ALU drive by class: R → alu_src 0, alu_op 00. LOAD/STORE/OPIMM → 1, 01. BRANCH → 0, 10. LUI → 1, 11. JAL/JALR → 1, 00.
  - BRANCH: pc_write=1, pc_src = alu_zero ? 01 : 00, instr_retired=1, then FETCH.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM (3):
  - dmem_req=1, with mem_read (LOAD) or mem_write (STORE); alu_src=1, alu_op=01 held.
  - Stay until dmem_ready.
  - STORE complete: pc_write=1, pc_src=00, instr_retired=1, then FETCH.
  - LOAD complete: go to WB.
- WB (4):
  - reg_write=1. wb_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - pc_write=1, pc_src: 01 for JAL, 10 for JALR, else 00.
  - instr_retired=1, then FETCH.
- FAULT (5):
  - fault=1; all strobes and requests 0.
  - Leave only via rst_n.
- Timeout:
  - Counter clears on entry to any wait (FETCH with run=1, or MEM) and increments each cycle req=1 and ready=0.
  - If ready is still 0 when the count reaches MEM_TIMEOUT-1, go to FAULT next cycle.
  - Ready in the same cycle as the limit wins (no fault).
- Retirement: each instruction asserts pc_write and instr_retired exactly once.
- Latency with zero-wait memories: branch 3 cycles, store 4, R/I/LUI/JAL/JALR 4, load 5.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- Defined:
  - Adds outputs cycle_count[31:0] and instret_count[31:0], both reset to 0.
  - cycle_count increments every cycle not in FAULT.
  - instret_count increments on instr_retired.
  - Both wrap modulo 2^32.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg: opcode localparams, state enum, instruction-class enum, and the pc_src / wb_sel / alu_op encodings. The main control unit uses the same alu_op encodings.
- One sub-module: mem_wait_timer (clear, count-enable, limit-hit output), instantiated once and shared by FETCH and MEM.

Test Plan:
1. R-type 0110011, imem_ready in the first FETCH cycle → DECODE, EXEC, WB. reg_write=1 for one cycle, pc_src=00, instr_retired once, 4 cycles total.
2. lw 0000011 with dmem_ready 3 cycles late → dmem_req and mem_read high 4 cycles, then WB with wb_sel=01. 8 cycles total.
3. beq 1100011, alu_zero=1 → EXEC: pc_write=1, pc_src=01, reg_write=0. Repeat with alu_zero=0 → pc_src=00.
4. MEM_TIMEOUT=4, imem_ready held 0 → fault=1 after 4 request cycles; fault stays 1 with strobes 0 until rst_n=0.
5. Opcode 7'b1111111 → DECODE goes to FAULT with no pc_write and no instr_retired. jalr 1100111 → WB: wb_sel=10, pc_src=10.
6. rst_n pulsed low mid-MEM during sw (mem_write=1) → mem_write drops in the same cycle; FETCH on release. With MULTICYCLE_PERF_EN, the counters read 0.
